grf_scoreboard: RTL
===================

// Module: grf_scoreboard
// PURPOSE
//  Parametrised general register file for the pipelined CPU, with per-register
//  pending-write scoreboard. Sits in ID (reads, issue) and WB (write-back).
//  Provides NUM_RD read ports with same-cycle write-through bypass, and busy
//  flags that the hazard unit uses to stall. Also has a flush and a sticky
//  write-back error flag.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register address width; DEPTH = 2**ADDR_W registers
//  NUM_RD  2   number of read ports (1..4)
//  CNT_W   2   width of the pending-write counter per register (max 2**CNT_W-1)
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               reset, synchronous, active-high
//  rd_addr   in   NUM_RD*ADDR_W   read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   read data, combinational, per port
//  rd_busy   out  NUM_RD          1 = port k's register has an uncovered pending write
//  iss_en    in   1               ID issues an instruction that will write iss_addr
//  iss_addr  in   ADDR_W          destination being reserved
//  iss_ready out  1               1 = issue is accepted this cycle
//  wr_en     in   1               WB write strobe
//  wr_addr   in   ADDR_W          WB destination
//  wr_data   in   DATA_W          WB data
//  wr_pc     in   32              PC of the WB instruction (trace only)
//  flush     in   1               clears all pending counters (pipeline squash)
//  wb_err    out  1               sticky: WB hit a register whose counter was 0
// BEHAVIOUR
//  - Reset: rst wins over everything. All regs = 0, all counters = 0,
//    wb_err = 0. rd_busy = 0, iss_ready = 1 after reset.
//  - Register 0 reads as 0, ignores writes, ignores issues and is never busy.
//  - Write: if wr_en and wr_addr != 0, reg[wr_addr] <= wr_data at posedge.
//  - Read: rd_data[k] = wr_data when wr_en && wr_addr == rd_addr[k] != 0
//    (bypass). Otherwise it is reg[rd_addr[k]]. Latency 0.
//  - Counter cnt[r]:
//    - +1 on an accepted issue to r.
//    - -1 on a write-back to r when cnt[r] > 0.
//    - Issue and write-back to r in the same cycle: cnt unchanged.
//  - rd_busy[k] = (cnt[a] > 1) || (cnt[a] == 1 && !(wr_en && wr_addr == a)),
//    where a = rd_addr[k] != 0. A write landing this cycle covers the last
//    pending write.
//  - iss_ready = !flush && !(iss_addr != 0 && cnt[iss_addr] == max
//    && !(wr_en && wr_addr == iss_addr)).
//    iss_en while !iss_ready: no counter change, and ID must hold.
//  - Write-back with cnt[wr_addr] == 0 and wr_addr != 0: data is still
//    written, the counter stays 0 (no underflow), and wb_err <= 1 until rst.
//  - flush: all cnt <= 0 at the next edge. A same-cycle issue is discarded.
//    A same-cycle WB data write still occurs, with no wb_err check.
//    Register data is never cleared by flush.
//  - Wrap-around: counters saturate at max via iss_ready and never wrap.
//    Address arithmetic does not wrap because DEPTH = 2**ADDR_W.
// CONFIGURATION
//  - GRF_TRACE_EN defined: each committed write (wr_en, wr_addr != 0, !rst)
//    prints $display("%d@%h: $%d <= %h", $time, wr_pc, wr_addr, wr_data)
//    at the posedge.
//  - Undefined: no display, and wr_pc is unused (lint waiver).
//  - Synthesised logic is identical either way.
// STRUCTURE
//  - Package grf_pkg: DATA_W/ADDR_W defaults, ZERO_REG = 0,
//    typedef reg_addr_t, typedef reg_data_t.
//  - Sub-module grf_pend_cnt: one CNT_W saturating up/down counter with
//    inc/dec/clr/full/nonzero. It is instantiated DEPTH-1 times in a
//    generate loop; register 0 has no counter.
//  - Data array and read muxes stay in the top level.
// TESTING
//  1. Reset, then read all 32 regs on both ports
//     -> rd_data = 0, rd_busy = 0, iss_ready = 1, wb_err = 0.
//  2. Issue $5, next cycle read $5 -> rd_busy = 1.
//     WB $5 = 32'hDEADBEEF with rd_addr = 5 -> same cycle rd_data = DEADBEEF,
//     rd_busy = 0. Next cycle cnt = 0.
//  3. Issue $7 three times (CNT_W = 2) -> 4th issue sees iss_ready = 0.
//     WB $7 and issue $7 in the same cycle -> iss_ready = 1, cnt stays 3.
//  4. WB $9 = 32'h1 with no prior issue -> reg $9 = 1, wb_err = 1,
//     and wb_err stays 1 across later traffic.
//  5. Issue $3 and $4, then flush together with issue $6
//     -> all rd_busy = 0 next cycle, $6 not busy.
//     Write $0 = FFFFFFFF -> reads of $0 = 0.
//  6. Assert rst with cnt[$3] = 2 and a concurrent WB
//     -> next cycle reg $3 = 0, not busy, wb_err = 0.
//     With GRF_TRACE_EN defined, check that the trace line format matches.

Source files
------------

// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults and types for the general register file
package grf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG = 0;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/grf_pend_cnt.sv
// grf_pend_cnt: saturating up/down pending-write counter for one register
module grf_pend_cnt
  import grf_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic             full,
  output logic             nonzero,
  output logic [CNT_W-1:0] cnt
);
  assign full = &cnt;
  assign nonzero = |cnt;
  // Simultaneous inc and dec cancel; the count neither wraps at max nor underflows at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + 1'b1;
    else if (dec && !inc && nonzero) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: register file with bypassed reads and pending-write scoreboard (optional trace: GRF_TRACE_EN)
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [31:0]              wr_pc,
  input  logic                     flush,
  output logic                     wb_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];
  logic [DEPTH-1:0]  full;
  logic [DEPTH-1:0]  nonzero;
  logic              wb_hit;
  assign wb_hit = wr_en && wr_addr != '0;
  assign iss_ready = !flush && !(iss_addr != '0 && full[iss_addr] && !(wb_hit && wr_addr == iss_addr));
  assign cnt[0] = '0;
  assign full[0] = 1'b0;
  assign nonzero[0] = 1'b0;
  for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
    grf_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (iss_en && iss_ready && iss_addr == ADDR_W'(r)),
      .dec    (wb_hit && wr_addr == ADDR_W'(r)),
      .clr    (flush),
      .full   (full[r]),
      .nonzero(nonzero[r]),
      .cnt    (cnt[r])
    );
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = wb_hit && wr_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[a];
    assign rd_busy[k] = nonzero[a] && !(cnt[a] == CNT_W'(1) && hit);
  end
  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (wb_hit) regs[wr_addr] <= wr_data;
  end
  // A write-back with nothing pending is an error that sticks until reset; flush suppresses the check.
  always_ff @(posedge clk) begin
    if (rst) wb_err <= 1'b0;
    else if (wb_hit && !flush && !nonzero[wr_addr]) wb_err <= 1'b1;
  end
`ifdef GRF_TRACE_EN
  // Trace every committed write-back.
  always @(posedge clk) begin
    if (!rst && wb_hit) $display("%d@%h: $%d <= %h", $time, wr_pc, wr_addr, wr_data);
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif
endmodule
